// File: rtl/byte_loaded_rv_core.sv
// Single-cycle RV32I-subset core. After reset it loads a 256-byte program one byte per clock,
// runs it from PC 0 until halt, and exposes registers and data memory through a byte readout.
module byte_loaded_rv_core #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 32
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       DataOrReg,
    input  logic [4:0] address,
    input  logic [7:0] instr_i,
    input  logic [1:0] vout_addr,
    output logic [7:0] value_o,
    output logic       is_positive,
    output logic [2:0] easter_egg
);

    localparam int PC_W = $clog2(IMEM_WORDS * 4);
    localparam int DA_W = $clog2(DMEM_WORDS);

    localparam logic [1:0] PH_LOAD = 2'd0;
    localparam logic [1:0] PH_RUN  = 2'd1;
    localparam logic [1:0] PH_HALT = 2'd2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [1:0]      phase;
    logic [PC_W-1:0] load_cnt;
    logic [PC_W-1:0] pc;
    logic [31:0]     imem [IMEM_WORDS];
    logic [31:0]     regs [32];
    logic [31:0]     dmem [DMEM_WORDS];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] rs1_val, rs2_val, alu_b, ea;
    logic [PC_W:0]   pc_plus4;
    logic [DA_W-1:0] d_idx;

    logic            rf_we;
    logic [31:0]     rf_wdata;
    logic            dm_we;
    logic            redirect;
    logic [PC_W-1:0] pc_next;
    logic            halt_now;
    logic            halt_after;

    assign instr   = imem[pc[PC_W-1:2]];
    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign funct7  = instr[31:25];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u   = {instr[31:12], 12'b0};

    // x0 is never written, so reading regs[0] always yields zero.
    assign rs1_val  = regs[rs1];
    assign rs2_val  = regs[rs2];
    assign alu_b    = (opcode == OP_R) ? rs2_val : imm_i;
    assign ea       = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign d_idx    = ea[DA_W+1:2];
    assign pc_plus4 = {1'b0, pc} + 4;

    logic unused_ok;
    assign unused_ok = ^{ea[31:DA_W+2], ea[1:0]};

    always_comb begin
        rf_we      = 1'b0;
        rf_wdata   = 32'b0;
        dm_we      = 1'b0;
        redirect   = 1'b0;
        pc_next    = pc_plus4[PC_W-1:0];
        halt_now   = (instr == 32'h0000_0000);
        case (opcode)
            OP_R, OP_I: begin
                rf_we = 1'b1;
                case (funct3)
                    3'b000:  rf_wdata = (opcode == OP_R && funct7 == 7'b0100000)
                                        ? rs1_val - alu_b : rs1_val + alu_b;
                    3'b111:  rf_wdata = rs1_val & alu_b;
                    3'b110:  rf_wdata = rs1_val | alu_b;
                    3'b100:  rf_wdata = rs1_val ^ alu_b;
                    3'b001:  rf_wdata = rs1_val << alu_b[4:0];
                    3'b101:  rf_wdata = rs1_val >> alu_b[4:0];
                    3'b010:  rf_wdata = {31'b0, $signed(rs1_val) < $signed(alu_b)};
                    default: rf_we = 1'b0;
                endcase
            end
            OP_LOAD: begin
                rf_we    = (funct3 == 3'b010);
                rf_wdata = dmem[d_idx];
            end
            OP_STORE:  dm_we = (funct3 == 3'b010);
            OP_BRANCH: begin
                if ((funct3 == 3'b000 && rs1_val == rs2_val) ||
                    (funct3 == 3'b001 && rs1_val != rs2_val)) begin
                    redirect = 1'b1;
                    pc_next  = pc + imm_b[PC_W-1:0];
                end
            end
            OP_JAL: begin
                rf_we    = 1'b1;
                rf_wdata = {{(32-PC_W){1'b0}}, pc} + 32'd4;
                redirect = 1'b1;
                pc_next  = pc + imm_j[PC_W-1:0];
            end
            OP_LUI: begin
                rf_we    = 1'b1;
                rf_wdata = imm_u;
            end
            default: ;
        endcase
        // Falling off the end of instruction memory halts; taken jumps simply wrap.
        halt_after = !redirect && pc_plus4[PC_W];
    end

    // Load, run and halt sequencing, with all storage cleared by reset.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            phase    <= PH_LOAD;
            load_cnt <= '0;
            pc       <= '0;
            for (int i = 0; i < IMEM_WORDS; i++) imem[i] <= 32'b0;
            for (int i = 0; i < 32; i++)         regs[i] <= 32'b0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= 32'b0;
        end else begin
            case (phase)
                PH_LOAD: begin
                    imem[load_cnt[PC_W-1:2]][{load_cnt[1:0], 3'b000} +: 8] <= instr_i;
                    load_cnt <= load_cnt + 1'b1;
                    if (load_cnt == {PC_W{1'b1}}) phase <= PH_RUN;
                end
                PH_RUN: begin
                    if (halt_now) begin
                        phase <= PH_HALT;
                    end else begin
                        if (rf_we && rd != 5'd0) regs[rd] <= rf_wdata;
                        if (dm_we) dmem[d_idx] <= rs2_val;
                        pc <= pc_next;
                        if (halt_after) phase <= PH_HALT;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [31:0] view_word;
    assign view_word   = DataOrReg ? dmem[address[DA_W-1:0]] : regs[address];
    assign value_o     = view_word[{vout_addr, 3'b000} +: 8];
    assign is_positive = !view_word[31] && (view_word != 32'b0);
    assign easter_egg  = {phase == PH_HALT, phase == PH_RUN, phase == PH_LOAD};

endmodule

// File: tb/tb_byte_loaded_rv_core.sv
// Directed self-checking bench for byte_loaded_rv_core: loads small programs byte-serially
// and inspects registers and data memory through the byte readout port.
module tb_byte_loaded_rv_core;

    logic       clk_i;
    logic       reset;
    logic       DataOrReg;
    logic [4:0] address;
    logic [7:0] instr_i;
    logic [1:0] vout_addr;
    logic [7:0] value_o;
    logic       is_positive;
    logic [2:0] easter_egg;

    int n_compared;
    int n_mismatched;
    logic [31:0] prog [64];

    byte_loaded_rv_core dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .DataOrReg  (DataOrReg),
        .address    (address),
        .instr_i    (instr_i),
        .vout_addr  (vout_addr),
        .value_o    (value_o),
        .is_positive(is_positive),
        .easter_egg (easter_egg)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    endtask

    // Streams prog[] one byte per posedge; must be entered just before a rising edge.
    task automatic load_prog();
        logic [31:0] w;
        for (int k = 0; k < 256; k++) begin
            w       = prog[k / 4];
            instr_i = w[8 * (k % 4) +: 8];
            if (k == 128) begin
                n_compared++;
                if (easter_egg !== 3'b001) begin
                    $display("[TB] FAIL load_phase: easter_egg=%b required=001", easter_egg);
                    n_mismatched++;
                end
            end
            @(negedge clk_i);
        end
        instr_i = 8'h00;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_halt(input string name);
        int cyc;
        cyc = 0;
        while (easter_egg !== 3'b100 && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
        end
        n_compared++;
        if (easter_egg !== 3'b100) begin
            $display("[TB] FAIL %s_halt_timeout: easter_egg=%b required=100", name, easter_egg);
            n_mismatched++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        DataOrReg = 1'b0;
        address   = 5'd0;
        vout_addr = 2'd0;
        instr_i   = 8'h00;
        #3;
        n_compared++;
        if (easter_egg !== 3'b001 || value_o !== 8'h00 || is_positive !== 1'b0) begin
            $display("[TB] FAIL reset_state: egg=%b val=%h pos=%b required 001/00/0",
                     easter_egg, value_o, is_positive);
            n_mismatched++;
        end
        @(negedge clk_i);
        reset = 1'b1;
        clear_prog();
        load_prog();
        n_compared++;
        if (easter_egg !== 3'b010) begin
            $display("[TB] FAIL zero_run_entry: easter_egg=%b required=010", easter_egg);
            n_mismatched++;
        end
        @(negedge clk_i);
        n_compared++;
        if (easter_egg !== 3'b100) begin
            $display("[TB] FAIL zero_halt_257: easter_egg=%b required=100", easter_egg);
            n_mismatched++;
        end
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 32; a++) begin
                for (int b = 0; b < 4; b++) begin
                    DataOrReg = s[0];
                    address   = a[4:0];
                    vout_addr = b[1:0];
                    #0.1;
                    n_compared++;
                    if (value_o !== 8'h00 || is_positive !== 1'b0) begin
                        $display("[TB] FAIL zero_readout src=%0d addr=%0d byte=%0d: val=%h pos=%b required 00/0",
                                 s, a, b, value_o, is_positive);
                        n_mismatched++;
                    end
                end
            end
        end
    endtask

    task automatic test_arith();
        clear_prog();
        prog[0] = 32'h0050_0093;
        prog[1] = 32'hFFD0_0113;
        prog[2] = 32'h0020_81B3;
        apply_reset();
        load_prog();
        wait_halt("arith");
        DataOrReg = 1'b0; address = 5'd3; vout_addr = 2'd0; #1;
        n_compared++;
        if (value_o !== 8'h02 || is_positive !== 1'b1) begin
            $display("[TB] FAIL add_x3_b0: val=%h pos=%b required 02/1", value_o, is_positive);
            n_mismatched++;
        end
        vout_addr = 2'd3; #1;
        n_compared++;
        if (value_o !== 8'h00) begin
            $display("[TB] FAIL add_x3_b3: val=%h required 00", value_o);
            n_mismatched++;
        end
        address = 5'd2; #1;
        n_compared++;
        if (value_o !== 8'hFF || is_positive !== 1'b0) begin
            $display("[TB] FAIL addi_neg_x2_b3: val=%h pos=%b required FF/0", value_o, is_positive);
            n_mismatched++;
        end
        vout_addr = 2'd0; #1;
        n_compared++;
        if (value_o !== 8'hFD) begin
            $display("[TB] FAIL addi_neg_x2_b0: val=%h required FD", value_o);
            n_mismatched++;
        end
    endtask

    task automatic test_lui_store();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h78; exp_b[1] = 8'h56; exp_b[2] = 8'h34; exp_b[3] = 8'h12;
        clear_prog();
        prog[0] = 32'h1234_50B7;
        prog[1] = 32'h6780_8093;
        prog[2] = 32'h0010_2423;
        apply_reset();
        load_prog();
        wait_halt("store");
        DataOrReg = 1'b1; address = 5'd2;
        for (int b = 0; b < 4; b++) begin
            vout_addr = b[1:0]; #1;
            n_compared++;
            if (value_o !== exp_b[b]) begin
                $display("[TB] FAIL sw_dmem2_b%0d: val=%h required %h", b, value_o, exp_b[b]);
                n_mismatched++;
            end
        end
        n_compared++;
        if (is_positive !== 1'b1) begin
            $display("[TB] FAIL sw_dmem2_pos: pos=%b required 1", is_positive);
            n_mismatched++;
        end
        address = 5'd1; vout_addr = 2'd0; #1;
        n_compared++;
        if (value_o !== 8'h00) begin
            $display("[TB] FAIL sw_dmem1_untouched: val=%h required 00", value_o);
            n_mismatched++;
        end
    endtask

    task automatic test_branch();
        clear_prog();
        prog[0] = 32'h0010_0093;
        prog[1] = 32'h0000_8463;
        prog[2] = 32'h0070_0113;
        prog[3] = 32'h0000_9463;
        prog[4] = 32'h0090_0113;
        apply_reset();
        load_prog();
        wait_halt("branch");
        DataOrReg = 1'b0; address = 5'd2; vout_addr = 2'd0; #1;
        n_compared++;
        if (value_o !== 8'h07) begin
            $display("[TB] FAIL branch_x2: val=%h required 07", value_o);
            n_mismatched++;
        end
        address = 5'd1; #1;
        n_compared++;
        if (value_o !== 8'h01) begin
            $display("[TB] FAIL branch_x1: val=%h required 01", value_o);
            n_mismatched++;
        end
    endtask

    task automatic test_x0_sub_slt();
        clear_prog();
        prog[0] = 32'h0050_0013;
        prog[1] = 32'h0010_0093;
        prog[2] = 32'h4010_0233;
        prog[3] = 32'h0002_22B3;
        apply_reset();
        load_prog();
        wait_halt("x0");
        DataOrReg = 1'b0; address = 5'd0; vout_addr = 2'd0; #1;
        n_compared++;
        if (value_o !== 8'h00 || is_positive !== 1'b0) begin
            $display("[TB] FAIL x0_zero: val=%h pos=%b required 00/0", value_o, is_positive);
            n_mismatched++;
        end
        address = 5'd4;
        for (int b = 0; b < 4; b++) begin
            vout_addr = b[1:0]; #1;
            n_compared++;
            if (value_o !== 8'hFF) begin
                $display("[TB] FAIL sub_x4_b%0d: val=%h required FF", b, value_o);
                n_mismatched++;
            end
        end
        address = 5'd5; vout_addr = 2'd0; #1;
        n_compared++;
        if (value_o !== 8'h01 || is_positive !== 1'b1) begin
            $display("[TB] FAIL slt_x5: val=%h pos=%b required 01/1", value_o, is_positive);
            n_mismatched++;
        end
    endtask

    task automatic test_pc_end_halt();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0010_8093;
        apply_reset();
        load_prog();
        wait_halt("pc_end");
        repeat (10) @(negedge clk_i);
        DataOrReg = 1'b0; address = 5'd1; vout_addr = 2'd0; #1;
        n_compared++;
        if (value_o !== 8'h40 || easter_egg !== 3'b100) begin
            $display("[TB] FAIL pc_end_freeze: x1=%h egg=%b required 40/100", value_o, easter_egg);
            n_mismatched++;
        end
    endtask

    task automatic test_mid_run_reset();
        clear_prog();
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0000_006F;
        apply_reset();
        load_prog();
        repeat (20) @(negedge clk_i);
        DataOrReg = 1'b0; address = 5'd1; vout_addr = 2'd0;
        #1;
        n_compared++;
        if (easter_egg !== 3'b010 || value_o !== 8'h05) begin
            $display("[TB] FAIL loop_running: egg=%b x1=%h required 010/05", easter_egg, value_o);
            n_mismatched++;
        end
        reset = 1'b0;
        #1;
        n_compared++;
        if (easter_egg !== 3'b001 || value_o !== 8'h00) begin
            $display("[TB] FAIL async_reset_clear: egg=%b x1=%h required 001/00", easter_egg, value_o);
            n_mismatched++;
        end
        #2;
        reset = 1'b1;
        clear_prog();
        prog[0] = 32'h0050_0113;
        load_prog();
        n_compared++;
        if (easter_egg !== 3'b010) begin
            $display("[TB] FAIL reload_run: egg=%b required 010", easter_egg);
            n_mismatched++;
        end
        wait_halt("reload");
        address = 5'd2; #1;
        n_compared++;
        if (value_o !== 8'h05) begin
            $display("[TB] FAIL reload_x2: val=%h required 05", value_o);
            n_mismatched++;
        end
        address = 5'd1; #1;
        n_compared++;
        if (value_o !== 8'h00) begin
            $display("[TB] FAIL reload_x1_cleared: val=%h required 00", value_o);
            n_mismatched++;
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_arith();
        test_lui_store();
        test_branch();
        test_x0_sub_slt();
        test_pc_end_halt();
        test_mid_run_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/byte_loaded_rv_core.md
Name: byte_loaded_rv_core

Overview:
- Single-cycle RV32I-subset processor with a byte-serial instruction loader and a byte-wide debug readout port.
- After reset it captures 256 instruction bytes from `instr_i`, one per clock, into a 64-word instruction memory, then executes from PC 0 until halt.
- Register file and data memory are observable one byte at a time through `address`, `vout_addr` and `DataOrReg`.

Parameters:
- IMEM_WORDS, 64: instruction memory depth in 32-bit words; load phase lasts IMEM_WORDS*4 cycles.
- DMEM_WORDS, 32: data memory depth in 32-bit words.

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- DataOrReg  in  1  readout source select: 1 = data memory, 0 = register file.
- address  in  5  readout word index (register number or data-memory word).
- instr_i  in  8  instruction byte stream, sampled each cycle during the load phase.
- vout_addr  in  2  readout byte select: 3 = bits[31:24], 2 = [23:16], 1 = [15:8], 0 = [7:0].
- value_o  out  8  selected byte of the selected word; combinational.
- is_positive  out  1  selected word is signed > 0 (bit31 = 0 and word != 0); combinational.
- easter_egg  out  3  status: [0] = loading, [1] = running, [2] = halted.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Load byte counter, PC, all 32 registers, all data memory and all instruction memory clear to 0.
  - Phase = LOAD; easter_egg = 3'b001.
  - value_o and is_positive follow the cleared storage (value_o = 0, is_positive = 0).
- LOAD phase:
  - Byte k (k = 0..255) is written into instruction word k/4, bits [8*(k%4)+7 : 8*(k%4)] (little-endian).
  - Counter increments each cycle. The cycle that writes byte 255 moves the phase to RUN on the next edge.
  - No instruction executes during LOAD.
- RUN phase (easter_egg = 3'b010): one instruction retires per cycle.
  - Fetch: imem[PC[7:2]].
  - Arithmetic is 32-bit two's complement, wrap-around; no traps.
- Supported instructions:
  - R-type (opcode 0110011): ADD, SUB (funct7 0100000), AND, OR, XOR, SLL, SRL, SLT (signed).
  - I-type (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI. Immediate is sign-extended 12 bits; shift amount is imm[4:0].
  - LW (0000011, funct3 010) and SW (0100011, funct3 010):
    - Effective address = rs1 + sext(imm); data word index = EA[6:2]; EA[1:0] ignored.
    - Load read is combinational; store writes on the clock edge.
  - BEQ/BNE (1100011): if taken, PC += sext(B-imm), else PC += 4.
  - JAL (1101111): rd <= PC+4; PC += sext(J-imm).
  - LUI (0110111): rd <= {imm[31:12], 12'b0}.
- Register and PC rules:
  - x0 always reads 0; writes to x0 are discarded.
  - Any other opcode is a NOP (PC += 4, no state change).
  - PC wraps modulo 256 bytes.
- Halt:
  - An instruction word equal to 32'h0000_0000, or PC reaching byte 256 via sequential increment, enters HALT.
  - In HALT (easter_egg = 3'b100) PC, registers and memories freeze. Only reset exits HALT.
- Readout: value_o = byte vout_addr of (DataOrReg ? dmem[address] : regs[address]).
  - With DataOrReg = 1, address[4:0] covers all 32 data words.
  - Readout never disturbs execution and is valid in every phase.

Test Plan:
- Reset released, instr_i stream all zero:
  - During load, easter_egg = 001.
  - Cycle 257: easter_egg = 100 (word 0 is zero, so the core halts immediately).
  - Every readout is 0.
- Load ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; then zero word:
  - After halt, DataOrReg = 0, address = 3: vout_addr 0 gives value_o = 8'h02; vout_addr 3 gives 8'h00; is_positive = 1.
  - address = 2, vout_addr 3: value_o = 8'hFF, is_positive = 0.
- Load LUI x1,0x12345; ADDI x1,x1,0x678; SW x1,8(x0); halt:
  - DataOrReg = 1, address = 2: vout_addr 3/2/1/0 read 12/34/56/78.
- Load ADDI x1,x0,1; BEQ x1,x0,+8; ADDI x2,x0,7; BNE x1,x0,+8; ADDI x2,x0,9; halt:
  - x2 = 7. The skipped ADDI x2,x0,9 leaves no effect.
- Load ADDI x0,x0,5; SUB x4,x0,x1 with x1 = 1; SLT x5,x4,x0:
  - x0 reads 0.
  - x4 = 32'hFFFFFFFF.
  - x5 = 1.
- Mid-RUN reset pulse (reset low for 3 ns):
  - Outputs clear immediately; easter_egg = 001; a full 256-byte reload is required before execution resumes.
